// File: rtl/seg7_readback.sv
// seg7_readback: debounces four active-low 7-seg buses, decodes them to BCD and flags blank/bad/backstep
module seg7_readback #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_en,
  input  logic [6:0]           seg0,
  input  logic [6:0]           seg1,
  input  logic [6:0]           seg2,
  input  logic [6:0]           seg3,
  input  logic                 clr_err,
  output logic [3:0]           digit0,
  output logic [3:0]           digit1,
  output logic [3:0]           digit2,
  output logic [3:0]           digit3,
  output logic                 valid,
  output logic [3:0]           blank,
  output logic [3:0]           bad,
  output logic                 update,
  output logic                 backstep,
  output logic [ERR_CNT_W-1:0] err_count
);
  typedef enum logic {SETTLE, LOCKED} state_t;
  state_t state, state_n;
  logic [27:0] raw, raw_prev, raw_prev_n;
  logic [7:0] cnt, cnt_n;
  logic commit, nv, bs;
  logic [3:0][3:0] d, dg, nd;
  logic [3:0] bl, bd;
  function automatic logic [5:0] dec(input logic [6:0] s);
    case (s)
      7'b1000000: return 6'd0;
      7'b1111001: return 6'd1;
      7'b0100100: return 6'd2;
      7'b0110000: return 6'd3;
      7'b0011001: return 6'd4;
      7'b0010010: return 6'd5;
      7'b0000010: return 6'd6;
      7'b1111000: return 6'd7;
      7'b0000000: return 6'd8;
      7'b0010000: return 6'd9;
      7'b1111111: return 6'b010000;
      default:    return 6'b100000;
    endcase
  endfunction
  assign raw = {seg3, seg2, seg1, seg0};
  genvar i;
  for (i = 0; i < 4; i++) begin : g_dec
    assign {bd[i], bl[i], dg[i]} = dec(raw[7*i +: 7]);
    assign nd[i] = (bl[i] | bd[i]) ? d[i] : dg[i];
  end
  assign nv = ~|{bl, bd};
  assign bs = valid & nv & (nd < d) & (nd != '0);
  assign {digit3, digit2, digit1, digit0} = d;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    raw_prev_n = raw_prev;
    commit = 1'b0;
    if (sample_en && raw != raw_prev) begin
      raw_prev_n = raw;
      cnt_n = 8'd1;
      state_n = SETTLE;
    end else if (sample_en && state == SETTLE) begin
      cnt_n = cnt + 8'd1;
      commit = cnt_n == 8'(STABLE_CYCLES);
      state_n = commit ? LOCKED : SETTLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SETTLE;
      cnt <= '0;
      raw_prev <= '1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      raw_prev <= raw_prev_n;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d <= '0;
      valid <= 1'b0;
      blank <= '0;
      bad <= '0;
      update <= 1'b0;
      backstep <= 1'b0;
      err_count <= '0;
    end else begin
      update <= commit;
      backstep <= commit & bs;
      if (commit) begin
        d <= nd;
        valid <= nv;
        blank <= bl;
        bad <= bd;
      end
      if (clr_err) err_count <= '0;
      else if (commit && |bd && !(&err_count)) err_count <= err_count + ERR_CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_seg7_readback.sv
// tb_seg7_readback: directed plus random stimulus against a run-length/decimal reference model
module tb_seg7_readback;
  logic clk = 0, rst_n = 0, sample_en = 0, clr_err = 0;
  logic [6:0] seg0 = '1, seg1 = '1, seg2 = '1, seg3 = '1;
  logic [3:0] digit0, digit1, digit2, digit3, blank, bad;
  logic valid, update, backstep;
  logic [7:0] err_count;
  int errors = 0, checks = 0;
  logic [6:0] segs [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [6:0] badp = 7'b0110110;
  int md [4];
  logic mvalid, mupd, mbs;
  logic [3:0] mblank, mbad;
  int merr, run;
  logic [27:0] last;
  logic have;
  seg7_readback #(.STABLE_CYCLES(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3), .clr_err(clr_err),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .valid(valid), .blank(blank), .bad(bad), .update(update), .backstep(backstep),
    .err_count(err_count)
  );
  always #5 clk = ~clk;
  function automatic logic [27:0] pt(input int a3, input int a2, input int a1, input int a0);
    return {segs[a3], segs[a2], segs[a1], segs[a0]};
  endfunction
  function automatic int decode(input logic [6:0] s);
    for (int k = 0; k < 10; k++) if (s == segs[k]) return k;
    return (s == 7'h7f) ? 10 : 11;
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic model(input logic [27:0] r, input logic e, input logic c, input logic rn);
    int nd [4];
    int v, oldn, newn;
    logic [3:0] nb, nbd;
    logic nv;
    mupd = 0;
    mbs = 0;
    if (!rn) begin
      md = '{0, 0, 0, 0};
      mvalid = 0; mblank = 0; mbad = 0; merr = 0; run = 0; have = 0;
      return;
    end
    if (e) begin
      if (have && r == last) run++;
      else begin
        run = 1;
        last = r;
        have = 1;
      end
    end
    nb = 0;
    nbd = 0;
    if (e && run == 4) begin
      for (int i = 0; i < 4; i++) begin
        v = decode(r[7*i +: 7]);
        nd[i] = (v < 10) ? v : md[i];
        nb[i] = (v == 10);
        nbd[i] = (v == 11);
      end
      nv = (nb == 0) && (nbd == 0);
      oldn = md[3] * 1000 + md[2] * 100 + md[1] * 10 + md[0];
      newn = nd[3] * 1000 + nd[2] * 100 + nd[1] * 10 + nd[0];
      mbs = mvalid && nv && newn < oldn && newn != 0;
      mupd = 1;
      md = nd;
      mvalid = nv;
      mblank = nb;
      mbad = nbd;
    end
    if (c) merr = 0;
    else if (mupd && nbd != 0 && merr < 255) merr++;
  endtask
  task automatic step(input logic [27:0] r, input logic e = 1, input logic c = 0, input logic rn = 1);
    {seg3, seg2, seg1, seg0} = r;
    sample_en = e;
    clr_err = c;
    rst_n = rn;
    @(posedge clk);
    model(r, e, c, rn);
    #1;
    chk("update", update, mupd);
    chk("backstep", backstep, mbs);
    chk("valid", valid, mvalid);
    chk("blank", blank, mblank);
    chk("bad", bad, mbad);
    chk("err_count", err_count, merr);
    chk("digit0", digit0, md[0]);
    chk("digit1", digit1, md[1]);
    chk("digit2", digit2, md[2]);
    chk("digit3", digit3, md[3]);
  endtask
  task automatic hold(input logic [27:0] r, input int n);
    for (int i = 0; i < n; i++) step(r);
  endtask
  initial begin
    logic [27:0] r;
    logic [27:0] ba, bb;
    int k;
    ba = {segs[1], badp, segs[3], segs[4]};
    bb = {segs[1], badp, segs[3], segs[5]};
    step('1, 0, 0, 0);
    step('1, 1, 0, 0);
    chk("reset_update", update, 0);
    chk("reset_err", err_count, 0);
    hold(pt(1, 2, 3, 4), 3);
    chk("no_early_commit", update, 0);
    step(pt(1, 2, 3, 4));
    chk("commit_1234", {digit3, digit2, digit1, digit0}, 16'h1234);
    hold(pt(1, 2, 3, 4), 3);
    hold(pt(1, 2, 3, 5), 2);
    hold(pt(1, 2, 3, 4), 4);
    chk("glitch_return", {digit3, digit2, digit1, digit0}, 16'h1234);
    hold(ba, 4);
    chk("bad_flags", bad, 4'b0100);
    chk("bad_err", err_count, 1);
    hold(bb, 3);
    step(bb, 1, 1);
    chk("clr_wins", err_count, 0);
    hold('1, 4);
    chk("all_blank", blank, 4'b1111);
    hold(pt(1, 2, 3, 4), 4);
    hold(pt(1, 2, 3, 0), 3);
    step(pt(1, 2, 3, 0));
    chk("backstep_pulse", backstep, 1);
    step(pt(1, 2, 3, 0));
    hold(pt(0, 0, 0, 0), 4);
    hold(pt(0, 0, 0, 1), 5);
    for (int i = 0; i < 15; i++) step(pt(5, 6, 7, 8), (i % 3) == 2);
    chk("sparse_commit", {digit3, digit2, digit1, digit0}, 16'h5678);
    hold(pt(4, 3, 2, 1), 2);
    step(pt(4, 3, 2, 1), 1, 0, 0);
    chk("mid_reset", {digit3, digit2, digit1, digit0}, 16'h0000);
    hold(pt(4, 3, 2, 1), 5);
    for (int i = 0; i < 260; i++) hold((i % 2) ? ba : bb, 4);
    chk("err_sat", err_count, 255);
    step(ba, 1, 1);
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) begin
        k = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 11) : $urandom_range(0, 9);
        r[7*i +: 7] = (k < 10) ? segs[k] : (k == 10) ? 7'h7f : badp;
      end
      k = $urandom_range(1, 6);
      for (int j = 0; j < k; j++) step(r, $urandom_range(0, 4) != 0, $urandom_range(0, 19) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg7_readback.md
Name: seg7_readback

Overview:
- Display-path self-check monitor for the stopwatch. It samples the four active-low 7-segment buses (HEX0..HEX3) that drive the board displays.
- It decodes each 7-bit pattern back to a BCD digit. A pattern must hold steady across several sample strobes before the block commits it.
- Committed digits, per-digit blank/invalid flags, an error counter and a time-went-backwards pulse go to debug LEDs/logic. This lets the display encoder be checked in-system.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before commit; legal range 2..255.
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock (single clock domain)
- rst_n  in  1  synchronous, active-low reset
- sample_en  in  1  sample strobe; inputs are examined only on cycles where it is high
- seg0  in  7  HEX0 pattern, active-low, bit6=g .. bit0=a (tens of ms)
- seg1  in  7  HEX1 pattern (hundreds of ms)
- seg2  in  7  HEX2 pattern (ones of s)
- seg3  in  7  HEX3 pattern (tens of s)
- clr_err  in  1  synchronous clear of err_count
- digit0..digit3  out  4 each  last committed BCD value per display
- valid  out  1  last commit had all four displays decoding to 0-9
- blank  out  4  per-display all-off (7'b1111111) at last commit
- bad  out  4  per-display illegal pattern at last commit
- update  out  1  one-cycle pulse on every commit
- backstep  out  1  one-cycle pulse when committed time decreased
- err_count  out  ERR_CNT_W  saturating count of commits containing a bad pattern

Behaviour:
- Decode is combinational per display.
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
  - 1111111 = blank.
  - Anything else = bad.
- Registers:
  - raw_prev: 28 bits, reset all-ones.
  - cnt: 8 bits, reset 0.
  - state: SETTLE/LOCKED, reset SETTLE.
- Reset values: digits 0, valid 0, blank 0000, bad 0000, update 0, backstep 0, err_count 0.
- Reset mid-settle discards any partial count.
- No action occurs when sample_en=0. cnt, state and raw_prev hold; update and backstep are 0.
- When sample_en=1 and raw != raw_prev: raw_prev<=raw, cnt<=1, state<=SETTLE. This applies in either state.
- When sample_en=1, raw == raw_prev and state is SETTLE: cnt<=cnt+1. If cnt+1 == STABLE_CYCLES, commit and state<=LOCKED.
- When sample_en=1, raw == raw_prev and state is LOCKED: hold. The block never re-commits an unchanged pattern.
- Commit timing: on the strobe edge that takes the STABLE_CYCLES-th consecutive identical sample. Outputs are visible the following cycle, and update is high for exactly that one cycle.
- Commit contents:
  - blank and bad are loaded from the decode.
  - digitN is loaded only where that display decoded 0-9; blank or bad displays hold their old digit.
  - valid <= (blank==0 && bad==0).
- If any bad bit is set at commit, err_count increments, saturating at all-ones. Blanks alone do not count as errors.
- backstep pulses when all three hold:
  - the previous valid was 1,
  - the new commit is valid,
  - {digit3,digit2,digit1,digit0}new < old as 16-bit unsigned (BCD ordering preserves magnitude) and new != 16'h0000.
- A return to 00.00 is a legal stopwatch reset and does not pulse backstep.
- clr_err sets err_count<=0. When clr_err and an increment coincide, clear wins.
- A pattern that flickers and returns to raw_prev value X restarts at cnt=1 on the change back; stability must be consecutive.

Test Plan:
- Reset; seg3..seg0 = 1111001, 0100100, 0110000, 0011001 ("12.34"); sample_en=1 constant -> update pulses exactly one cycle after the 4th strobe; digit3..0=1,2,3,4; valid=1; bad=0000; no further update.
- Change to "12.35" for 2 strobes, then back to "12.34" for 4 strobes -> no commit during the glitch; one update after the 4th strobe of the return; digits still 1,2,3,4.
- seg2=0110110 (illegal) with others "1_.34" held 4 strobes -> bad=0100, valid=0, err_count=1, digit2 holds 2; clr_err on the same cycle as a second bad commit -> err_count=0.
- All four seg=1111111 for 4 strobes -> blank=1111, valid=0, err_count unchanged, digits held.
- Commit "12.34", then "12.30" -> backstep=1 for one cycle; then "00.00" -> backstep=0; then "00.01" -> no backstep.
- sample_en toggled every 3rd cycle with a steady pattern -> commit on the 4th strobe (cycle ~12); assert rst_n=0 after 2 strobes of a new pattern -> all outputs return to reset values and the pattern needs 4 fresh strobes; force 255 bad commits with ERR_CNT_W=8 -> err_count saturates at 255.
